// File: rtl/lfsr_rx.sv
// ============================================================================
// Module   : lfsr_rx
// Brief    : LSB-first serial receiver that checks a word against a local LFSR.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lfsr_rx #(
    parameter int NO_OF_BITS   = 4,
    parameter int SHIFT_CYCLES = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NO_OF_BITS-1:0] i_sead,
    input  logic                  i_valid,
    input  logic                  i_in,
    output logic [NO_OF_BITS-1:0] o_data,
    output logic                  o_done,
    output logic                  o_pass,
    output logic                  o_err
);

    localparam int c_SHIFT_W = $clog2(SHIFT_CYCLES + 1);
    localparam int c_BIT_W   = $clog2(NO_OF_BITS + 1);

    localparam logic [c_SHIFT_W-1:0] c_SHIFT_LAST = c_SHIFT_W'(SHIFT_CYCLES - 1);
    localparam logic [c_BIT_W-1:0]   c_BITS_FULL  = c_BIT_W'(NO_OF_BITS);

    typedef enum logic [1:0] {
        ST_CALC = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [NO_OF_BITS-1:0]   exp_q;
    logic [NO_OF_BITS-1:0]   exp_d;
    logic [NO_OF_BITS-1:0]   data_q;
    logic [NO_OF_BITS-1:0]   data_d;
    logic [c_SHIFT_W-1:0]    shift_cnt_q;
    logic [c_BIT_W-1:0]      bit_cnt_q;
    logic                    done_q;
    logic                    pass_q;
    logic                    err_q;

    logic                    w_fb;
    logic                    w_bits_full;
    logic                    w_shift_last;

    assign w_fb         = exp_q[0] ^ exp_q[1] ^ exp_q[2];
    assign exp_d        = {w_fb, exp_q[NO_OF_BITS-1:1]};
    assign data_d       = {i_in, data_q[NO_OF_BITS-1:1]};
    assign w_bits_full  = (bit_cnt_q == c_BITS_FULL);
    assign w_shift_last = (shift_cnt_q == c_SHIFT_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_CALC;
            exp_q       <= i_sead;
            data_q      <= '0;
            shift_cnt_q <= '0;
            bit_cnt_q   <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // Capture runs alongside the LFSR so early bits are never lost.
            if (i_valid) begin
                if (w_bits_full) begin
                    err_q <= 1'b1;
                end else begin
                    data_q    <= data_d;
                    bit_cnt_q <= bit_cnt_q + c_BIT_W'(1);
                end
            end

            case (state_q)
                ST_CALC: begin
                    exp_q       <= exp_d;
                    shift_cnt_q <= shift_cnt_q + c_SHIFT_W'(1);
                    if (w_shift_last) begin
                        state_q <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    // Compare uses the word as it stood before this edge.
                    if (w_bits_full) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        pass_q  <= (data_q == exp_q);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_CALC;
                end
            endcase
        end
    end

    assign o_data = data_q;
    assign o_done = done_q;
    assign o_pass = pass_q;
    assign o_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_rx.sv
// ============================================================================
// Module   : tb_lfsr_rx
// Brief    : Scoreboard bench for lfsr_rx with hand-computed expected outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lfsr_rx;

    logic       clk;
    logic       rst_n;
    logic [3:0] sead;
    logic       valid;
    logic       din;
    logic [3:0] o_data;
    logic       o_done;
    logic       o_pass;
    logic       o_err;

    lfsr_rx #(
        .NO_OF_BITS   (4),
        .SHIFT_CYCLES (8)
    ) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_sead  (sead),
        .i_valid (valid),
        .i_in    (din),
        .o_data  (o_data),
        .o_done  (o_done),
        .o_pass  (o_pass),
        .o_err   (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              at;
        logic [3:0]      data;
        logic            done;
        logic            pass;
        logic            err;
        logic [8*12-1:0] name;
    } exp_t;

    exp_t q[$];
    int   edge_cnt = 0;
    int   base     = 0;
    int   checks   = 0;
    int   errors   = 0;

    always @(posedge clk) edge_cnt++;

    // Monitor: pops every expectation due at the edge just completed.
    exp_t ent;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at <= edge_cnt) begin
            ent = q.pop_front();
            checks++;
            if (ent.at < edge_cnt) begin
                errors++;
                $display("FAIL %0s missed: checked at edge %0d, required edge %0d",
                         ent.name, edge_cnt, ent.at);
            end else if ({o_data, o_done, o_pass, o_err} !==
                         {ent.data, ent.done, ent.pass, ent.err}) begin
                errors++;
                $display("FAIL %0s @edge %0d: got data=%b done=%b pass=%b err=%b, want data=%b done=%b pass=%b err=%b",
                         ent.name, edge_cnt, o_data, o_done, o_pass, o_err,
                         ent.data, ent.done, ent.pass, ent.err);
            end
        end
    end

    function automatic void push(input logic [8*12-1:0] name, input int at,
                                 input logic [3:0] d, input logic dn,
                                 input logic ps, input logic er);
        exp_t e;
        e.at   = at;
        e.data = d;
        e.done = dn;
        e.pass = ps;
        e.err  = er;
        e.name = name;
        q.push_back(e);
    endfunction

    // Starts and ends at a falling edge; edge 1 of the test is base+1.
    task automatic reset_dut(input logic [3:0] seed, input int n);
        rst_n = 1'b0;
        sead  = seed;
        for (int i = 0; i < n; i++) begin
            valid = i[0];
            din   = 1'b1;
            push("rst", edge_cnt + 1, 4'b0000, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        valid = 1'b0;
        din   = 1'b0;
        base  = edge_cnt;
    endtask

    task automatic drive(input logic [31:0] vmask, input logic [31:0] dmask, input int n);
        for (int e = 1; e <= n; e++) begin
            valid = vmask[e];
            din   = dmask[e];
            @(negedge clk);
        end
        valid = 1'b0;
        din   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        sead  = 4'b0000;
        valid = 1'b0;
        din   = 1'b0;
        @(negedge clk);

        // Seed 1001, correct bits 0,0,1,1 on edges 9-12.
        reset_dut(4'b1001, 1);
        push("t1_nobits", base + 8,  4'b0000, 1'b0, 1'b0, 1'b0);
        push("t1_pre",    base + 12, 4'b1100, 1'b0, 1'b0, 1'b0);
        push("t1_done",   base + 13, 4'b1100, 1'b1, 1'b1, 1'b0);
        push("t1_hold",   base + 16, 4'b1100, 1'b1, 1'b1, 1'b0);
        drive(32'h0000_1E00, 32'h0000_1800, 16);

        // Seed 1001, wrong bits 0,1,1,1.
        reset_dut(4'b1001, 1);
        push("t2_pre",  base + 12, 4'b1110, 1'b0, 1'b0, 1'b0);
        push("t2_done", base + 13, 4'b1110, 1'b1, 1'b0, 1'b0);
        push("t2_hold", base + 16, 4'b1110, 1'b1, 1'b0, 1'b0);
        drive(32'h0000_1E00, 32'h0000_1C00, 16);

        // Seed 0000, gapped early bits on edges 2,4,6,7.
        reset_dut(4'b0000, 1);
        push("t3_bits", base + 7, 4'b0000, 1'b0, 1'b0, 1'b0);
        push("t3_wait", base + 8, 4'b0000, 1'b0, 1'b0, 1'b0);
        push("t3_done", base + 9, 4'b0000, 1'b1, 1'b1, 1'b0);
        drive(32'h0000_00D4, 32'h0000_0000, 12);

        // Seed 1001, correct bits then an extra pulse on edge 15.
        reset_dut(4'b1001, 1);
        push("t4_done",  base + 13, 4'b1100, 1'b1, 1'b1, 1'b0);
        push("t4_noerr", base + 14, 4'b1100, 1'b1, 1'b1, 1'b0);
        push("t4_err",   base + 15, 4'b1100, 1'b1, 1'b1, 1'b1);
        push("t4_stick", base + 17, 4'b1100, 1'b1, 1'b1, 1'b1);
        drive(32'h0000_9E00, 32'h0000_9800, 17);

        // Partial capture, then reset with a new seed mid-capture.
        reset_dut(4'b1001, 1);
        push("t5_part", base + 3, 4'b1100, 1'b0, 1'b0, 1'b0);
        drive(32'h0000_000C, 32'h0000_000C, 4);
        reset_dut(4'b0000, 1);
        push("t5_pre",  base + 12, 4'b0000, 1'b0, 1'b0, 1'b0);
        push("t5_done", base + 13, 4'b0000, 1'b1, 1'b1, 1'b0);
        drive(32'h0000_1E00, 32'h0000_0000, 14);

        // Long reset with i_valid toggling keeps everything at zero.
        reset_dut(4'b1001, 3);
        push("t6_after", base + 1, 4'b0000, 1'b0, 1'b0, 1'b0);
        drive(32'h0000_0000, 32'h0000_0000, 2);

        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations never checked, required 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
